// File: rtl/move_ctrl.sv
// Drop sequencer for the 8x8 board store: scans a column bottom-up, writes the lowest empty cell, reports.
// Optional win detection is built when MOVE_CTRL_WIN_CHECK_EN is defined.
module move_ctrl #(
  parameter int INIT_CYCLES = 64
`ifdef MOVE_CTRL_WIN_CHECK_EN
  , parameter int WIN_LEN = 4
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_col,
  input  logic [1:0]   req_player,
  input  logic [127:0] board_in,
  output logic         brd_enable,
  output logic         brd_write,
  output logic [2:0]   brd_row,
  output logic [2:0]   brd_col,
  output logic [1:0]   brd_data,
  output logic         rsp_valid,
  output logic [1:0]   rsp_status,
  output logic [2:0]   rsp_row,
  output logic         rsp_win,
  output logic         init_done
);

  localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_SCAN  = 3'd2,
    S_WRITE = 3'd3,
    S_CHECK = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_init_cnt;
  logic [2:0]      r_col, r_row;
  logic [1:0]      r_player;
  logic [1:0]      w_cell;
  logic            w_bad_player;

  logic            w_req_ready, w_init_done, w_brd_en, w_rsp_valid, w_rsp_win;
  logic [2:0]      w_brd_row, w_brd_col, w_rsp_row;
  logic [1:0]      w_brd_data, w_rsp_status;
  logic            r_req_ready, r_init_done, r_brd_en, r_rsp_valid;
  logic [2:0]      r_brd_row, r_brd_col, r_rsp_row;
  logic [1:0]      r_brd_data, r_rsp_status;

  assign w_cell       = board_in[{r_row, r_col, 1'b0} +: 2];
  assign w_bad_player = (req_player == 2'b00) || (req_player == 2'b11);

`ifdef MOVE_CTRL_WIN_CHECK_EN
  logic [1:0] r_dir;
  logic       r_win, r_rsp_win, w_hit;
  int         w_dr, w_dc, w_run;

  // Contiguous run of player p through (row,col) along (dr,dc), both senses, clipped at the edges.
  function automatic int run_len(input logic [127:0] b, input int row, input int col,
                                 input int dr, input int dc, input logic [1:0] p);
    int n, r, c;
    logic go;
    logic [6:0] idx;
    n = 1;
    for (int s = -1; s <= 1; s += 2) begin
      go = 1'b1;
      r  = row;
      c  = col;
      for (int k = 1; k < 8; k++) begin
        r = r + s * dr;
        c = c + s * dc;
        if (go && r >= 0 && r < 8 && c >= 0 && c < 8) begin
          idx = 7'((8 * r + c) * 2);
          if (b[idx +: 2] == p) n = n + 1;
          else go = 1'b0;
        end else begin
          go = 1'b0;
        end
      end
    end
    return n;
  endfunction

  // Direction under test this cycle: horizontal, vertical, diag /, diag \.
  always_comb begin
    w_dr = 0;
    w_dc = 1;
    case (r_dir)
      2'd0:    begin w_dr = 0; w_dc = 1;  end
      2'd1:    begin w_dr = 1; w_dc = 0;  end
      2'd2:    begin w_dr = 1; w_dc = 1;  end
      2'd3:    begin w_dr = 1; w_dc = -1; end
      default: begin w_dr = 0; w_dc = 1;  end
    endcase
    w_run = run_len(board_in, int'(r_row), int'(r_col), w_dr, w_dc, r_player);
    w_hit = (w_run >= WIN_LEN);
  end

  // Direction counter and accumulated win flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir <= 2'd0;
      r_win <= 1'b0;
    end else if (r_state == S_WRITE) begin
      r_dir <= 2'd0;
      r_win <= 1'b0;
    end else if (r_state == S_CHECK) begin
      r_win <= r_win | w_hit;
      if (r_dir != 2'd3) r_dir <= r_dir + 2'd1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (r_init_cnt == CW'(INIT_CYCLES - 1)) w_next = S_IDLE; else w_next = S_INIT;
      S_IDLE:  if (req_valid) w_next = w_bad_player ? S_RESP : S_SCAN; else w_next = S_IDLE;
      S_SCAN: begin
        if (w_cell == 2'b00)     w_next = S_WRITE;
        else if (r_row == 3'd7)  w_next = S_RESP;
        else                     w_next = S_SCAN;
      end
`ifdef MOVE_CTRL_WIN_CHECK_EN
      S_WRITE: w_next = S_CHECK;
      S_CHECK: if (r_dir == 2'd3) w_next = S_RESP; else w_next = S_CHECK;
`else
      S_WRITE: w_next = S_RESP;
`endif
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output values for the coming state; registered below so outputs are glitch-free.
  always_comb begin
    w_req_ready = (w_next == S_IDLE);
    w_init_done = (w_next != S_INIT);
    if (w_next == S_WRITE) begin
      w_brd_en   = 1'b1;
      w_brd_row  = r_row;
      w_brd_col  = r_col;
      w_brd_data = r_player;
    end else begin
      w_brd_en   = 1'b0;
      w_brd_row  = 3'd0;
      w_brd_col  = 3'd0;
      w_brd_data = 2'b00;
    end
    if (w_next == S_RESP) begin
      w_rsp_valid = 1'b1;
      case (r_state)
        S_IDLE:  begin w_rsp_status = 2'b10; w_rsp_row = 3'd0;  end
        S_SCAN:  begin w_rsp_status = 2'b01; w_rsp_row = 3'd0;  end
        default: begin w_rsp_status = 2'b00; w_rsp_row = r_row; end
      endcase
`ifdef MOVE_CTRL_WIN_CHECK_EN
      w_rsp_win = (r_state == S_CHECK) && (r_win || w_hit);
`else
      w_rsp_win = 1'b0;
`endif
    end else begin
      w_rsp_valid  = 1'b0;
      w_rsp_status = 2'b00;
      w_rsp_row    = 3'd0;
      w_rsp_win    = 1'b0;
    end
  end

  // Init counter, latched request and scan row pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_cnt <= '0;
      r_col      <= 3'd0;
      r_player   <= 2'b00;
      r_row      <= 3'd0;
    end else begin
      case (r_state)
        S_INIT: if (r_init_cnt != CW'(INIT_CYCLES - 1)) r_init_cnt <= r_init_cnt + CW'(1);
        S_IDLE: if (req_valid) begin
          r_col    <= req_col;
          r_player <= req_player;
          r_row    <= 3'd0;
        end
        S_SCAN: if (w_cell != 2'b00 && r_row != 3'd7) r_row <= r_row + 3'd1;
        default: ;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b0;
      r_init_done  <= 1'b0;
      r_brd_en     <= 1'b0;
      r_brd_row    <= 3'd0;
      r_brd_col    <= 3'd0;
      r_brd_data   <= 2'b00;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= 2'b00;
      r_rsp_row    <= 3'd0;
    end else begin
      r_req_ready  <= w_req_ready;
      r_init_done  <= w_init_done;
      r_brd_en     <= w_brd_en;
      r_brd_row    <= w_brd_row;
      r_brd_col    <= w_brd_col;
      r_brd_data   <= w_brd_data;
      r_rsp_valid  <= w_rsp_valid;
      r_rsp_status <= w_rsp_status;
      r_rsp_row    <= w_rsp_row;
    end
  end

`ifdef MOVE_CTRL_WIN_CHECK_EN
  // Win flag output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rsp_win <= 1'b0;
    else        r_rsp_win <= w_rsp_win;
  end
  assign rsp_win = r_rsp_win;
`else
  assign rsp_win = 1'b0;
`endif

  assign req_ready  = r_req_ready;
  assign init_done  = r_init_done;
  assign brd_enable = r_brd_en;
  assign brd_write  = r_brd_en;
  assign brd_row    = r_brd_row;
  assign brd_col    = r_brd_col;
  assign brd_data   = r_brd_data;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_status = r_rsp_status;
  assign rsp_row    = r_rsp_row;

endmodule

// File: tb/tb_move_ctrl.sv
// Directed bench for move_ctrl; also models the board store that the DUT writes.
module tb_move_ctrl;

`ifdef MOVE_CTRL_WIN_CHECK_EN
  localparam int CHK = 4;
  localparam bit EN  = 1'b1;
`else
  localparam int CHK = 0;
  localparam bit EN  = 1'b0;
`endif
  localparam logic [1:0] ST_OK = 2'b00, ST_FULL = 2'b01, ST_BAD = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_col = 3'd0;
  logic [1:0]   req_player = 2'b00;
  logic [127:0] board = '0;
  logic         clr = 1'b0;
  logic         brd_enable, brd_write, rsp_valid, rsp_win, init_done;
  logic [2:0]   brd_row, brd_col, rsp_row;
  logic [1:0]   brd_data, rsp_status;
  int           n_writes = 0;
  int           n_pass = 0;
  int           n_total = 0;

  move_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_col(req_col), .req_player(req_player), .board_in(board),
    .brd_enable(brd_enable), .brd_write(brd_write), .brd_row(brd_row),
    .brd_col(brd_col), .brd_data(brd_data), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .rsp_row(rsp_row), .rsp_win(rsp_win),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Board store: takes the write on the edge that ends the WRITE cycle.
  always @(posedge clk) begin
    if (clr) board <= '0;
    else if (brd_enable && brd_write) board[{brd_row, brd_col, 1'b0} +: 2] <= brd_data;
    if (brd_enable) n_writes <= n_writes + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_board();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic wait_init(input string name);
    logic bad;
    bad = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      @(posedge clk); #1;
      if (req_ready !== 1'b0 || init_done !== 1'b0) bad = 1'b1;
    end
    n_total++;
    if (bad !== 1'b0) $display("FAIL %s_init_window: ready/done seen high before 64 cycles", name);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({req_ready, init_done} !== 2'b11)
      $display("FAIL %s_init_done: got ready,done=%b want 11", name, {req_ready, init_done});
    else n_pass++;
  endtask

  // Follow one accepted request from cycle 1 until its response.
  task automatic watch(input string name, input logic [2:0] col, input logic [1:0] p,
                       input logic [1:0] st, input logic [2:0] row, input logic win);
    int k, rsp_cyc, wr_cyc, exp_rsp, exp_wr, w0;
    logic [2:0] g_row, w_row, w_col;
    logic [1:0] g_st, w_data;
    logic g_win, fields_ok, exp_win;
    w0 = n_writes; k = 1; rsp_cyc = -1; wr_cyc = -1; fields_ok = 1'b1;
    g_row = 3'd0; g_st = 2'b00; g_win = 1'b0; w_row = 3'd0; w_col = 3'd0; w_data = 2'b00;
    exp_win = EN ? win : 1'b0;
    exp_rsp = (st == ST_OK) ? int'(row) + 3 + CHK : ((st == ST_FULL) ? 9 : 1);
    exp_wr  = (st == ST_OK) ? int'(row) + 2 : -1;
    while (rsp_cyc < 0 && k <= 30) begin
      if (brd_enable !== brd_write) fields_ok = 1'b0;
      if (brd_enable === 1'b1) begin
        if (wr_cyc < 0) begin wr_cyc = k; w_row = brd_row; w_col = brd_col; w_data = brd_data; end
        else wr_cyc = 99;
      end else if ({brd_row, brd_col, brd_data} !== 8'd0) fields_ok = 1'b0;
      if (rsp_valid === 1'b1) begin
        rsp_cyc = k; g_st = rsp_status; g_row = rsp_row; g_win = rsp_win;
      end else begin
        if ({rsp_status, rsp_row, rsp_win} !== 6'd0) fields_ok = 1'b0;
        @(posedge clk); #1;
        k++;
      end
    end
    n_total++;
    if (rsp_cyc !== exp_rsp) $display("FAIL %s_rsp_cycle: got %0d want %0d", name, rsp_cyc, exp_rsp);
    else n_pass++;
    n_total++;
    if (g_st !== st) $display("FAIL %s_status: got %b want %b", name, g_st, st);
    else n_pass++;
    n_total++;
    if (g_row !== row) $display("FAIL %s_row: got %0d want %0d", name, g_row, row);
    else n_pass++;
    n_total++;
    if (g_win !== exp_win) $display("FAIL %s_win: got %b want %b", name, g_win, exp_win);
    else n_pass++;
    n_total++;
    if (wr_cyc !== exp_wr) $display("FAIL %s_write_cycle: got %0d want %0d", name, wr_cyc, exp_wr);
    else n_pass++;
    if (st == ST_OK) begin
      n_total++;
      if ({w_row, w_col, w_data} !== {row, col, p})
        $display("FAIL %s_write_fields: got r%0d c%0d d%b want r%0d c%0d d%b",
                 name, w_row, w_col, w_data, row, col, p);
      else n_pass++;
    end
    n_total++;
    if (fields_ok !== 1'b1) $display("FAIL %s_idle_fields: outputs nonzero outside their pulse", name);
    else n_pass++;
    n_total++;
    if (n_writes - w0 !== ((st == ST_OK) ? 1 : 0))
      $display("FAIL %s_write_count: got %0d want %0d", name, n_writes - w0, (st == ST_OK) ? 1 : 0);
    else n_pass++;
  endtask

  task automatic do_drop(input string name, input logic [2:0] col, input logic [1:0] p,
                         input logic [1:0] st, input logic [2:0] row, input logic win);
    int t;
    t = 0;
    while (req_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL %s_ready_timeout: got %b want 1", name, req_ready);
    else n_pass++;
    req_valid = 1'b1; req_col = col; req_player = p;
    @(posedge clk); #1;
    req_valid = 1'b0;
    watch(name, col, p, st, row, win);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    clear_board();
    req_valid = 1'b1; req_col = 3'd0; req_player = 2'b01;
    @(posedge clk); #1;
    n_total++;
    if ({req_ready, init_done, brd_enable, brd_write, brd_row, brd_col, brd_data,
         rsp_valid, rsp_status, rsp_row, rsp_win} !== 19'd0)
      $display("FAIL reset_outputs: got nonzero outputs want all 0");
    else n_pass++;
    rst_n = 1'b1;
    wait_init("reset");
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_total++;
    if (req_ready !== 1'b0) $display("FAIL first_accept: got ready=%b want 0", req_ready);
    else n_pass++;
    watch("first", 3'd0, 2'b01, ST_OK, 3'd0, 1'b0);
  endtask

  task automatic test_drop();
    do_drop("c3_p1", 3'd3, 2'b01, ST_OK, 3'd0, 1'b0);
    do_drop("c3_p2", 3'd3, 2'b10, ST_OK, 3'd1, 1'b0);
    do_drop("c7_p2", 3'd7, 2'b10, ST_OK, 3'd0, 1'b0);
  endtask

  task automatic test_col_full();
    for (int i = 0; i < 8; i++)
      do_drop("fill", 3'd1, i[0] ? 2'b10 : 2'b01, ST_OK, 3'(i), 1'b0);
    do_drop("full", 3'd1, 2'b01, ST_FULL, 3'd0, 1'b0);
  endtask

  task automatic test_bad_player();
    do_drop("bad00", 3'd2, 2'b00, ST_BAD, 3'd0, 1'b0);
    do_drop("bad11", 3'd2, 2'b11, ST_BAD, 3'd0, 1'b0);
    do_drop("after_bad", 3'd2, 2'b10, ST_OK, 3'd0, 1'b0);
  endtask

  task automatic test_win();
    logic [2:0] dcol [10] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
    logic [1:0] dply [10] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    logic [2:0] drow [10] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3};
    clear_board();
    for (int c = 0; c < 4; c++)
      do_drop("horiz", 3'(c), 2'b01, ST_OK, 3'd0, c == 3);
    clear_board();
    do_drop("col3_first", 3'd3, 2'b01, ST_OK, 3'd0, 1'b0);
    clear_board();
    for (int r = 0; r < 4; r++)
      do_drop("vert", 3'd5, 2'b10, ST_OK, 3'(r), r == 3);
    clear_board();
    for (int i = 0; i < 10; i++)
      do_drop("diag", dcol[i], dply[i], ST_OK, drow[i], i == 9);
  endtask

  task automatic test_reset_mid();
    int w0;
    logic bad;
    clear_board();
    for (int i = 0; i < 5; i++)
      do_drop("stack", 3'd6, i[0] ? 2'b10 : 2'b01, ST_OK, 3'(i), 1'b0);
    while (req_ready !== 1'b1) begin @(posedge clk); #1; end
    w0 = n_writes;
    req_valid = 1'b1; req_col = 3'd6; req_player = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({req_ready, init_done, brd_enable, brd_write, brd_row, brd_col, brd_data,
         rsp_valid, rsp_status, rsp_row, rsp_win} !== 19'd0)
      $display("FAIL midreset_outputs: got init_done=%b ready=%b want all 0", init_done, req_ready);
    else n_pass++;
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if ((rsp_valid | brd_enable | init_done | req_ready) !== 1'b0) bad = 1'b1;
    end
    n_total++;
    if (bad !== 1'b0) $display("FAIL midreset_hold: got activity during reset want none");
    else n_pass++;
    rst_n = 1'b1;
    wait_init("midreset");
    n_total++;
    if (n_writes !== w0) $display("FAIL midreset_no_write: got %0d writes want %0d", n_writes - w0, 0);
    else n_pass++;
    do_drop("recover", 3'd6, 2'b10, ST_OK, 3'd5, 1'b0);
  endtask

  initial begin
    test_reset();
    test_drop();
    test_col_full();
    test_bad_player();
    test_win();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
